fetch_decode_queue: RTL and testbench
=====================================

// Module: fetch_decode_queue
// PURPOSE
//   Decoupling instruction queue between instruction fetch and decode.
//   Captures {pc, pc_next, instruction} triples from fetch with a valid/ready handshake.
//   Presents them in order to decode. Absorbs decode stalls so fetch never has to re-read ROM.
//   A single-cycle flush discards all queued entries on a taken branch or jump.
// PARAMETERS
//   DEPTH  2            number of entries; power of two, >= 2
//   XLEN   32           width of pc, pc_next and instruction
//   NOP    32'h00000013 instruction driven on out_instruction while the queue is empty (addi x0,x0,0)
// PORTS
//   clk              in   1                    rising-edge clock
//   rst              in   1                    synchronous reset, active-high
//   flush            in   1                    discard all entries (branch redirect)
//   in_valid         in   1                    fetch offers an entry
//   in_ready         out  1                    queue can accept an entry this cycle
//   in_pc            in   XLEN                 pc of offered instruction
//   in_pc_next       in   XLEN                 pc + 4 of offered instruction
//   in_instruction   in   XLEN                 fetched instruction word
//   out_valid        out  1                    head entry is valid for decode
//   out_ready        in   1                    decode consumes the head this cycle
//   out_pc           out  XLEN                 head pc
//   out_pc_next      out  XLEN                 head pc_next
//   out_instruction  out  XLEN                 head instruction; NOP when empty
//   count            out  $clog2(DEPTH+1)      number of occupied entries
// BEHAVIOUR
//   - Storage: circular buffer of DEPTH entries, write pointer wr_ptr, read pointer rd_ptr, and count.
//     Both pointers wrap modulo DEPTH.
//   - push = in_valid & in_ready & ~flush
//   - pop = out_valid & out_ready & ~flush
//   - in_ready = (count != DEPTH) & ~flush. It does not depend on out_ready: a full queue refuses
//     a push even if a pop occurs in the same cycle. No combinational path from out_ready to in_ready.
//   - out_valid = (count != 0) & ~flush.
//   - out_pc, out_pc_next, out_instruction: read combinationally from the entry at rd_ptr.
//     When count == 0 they are forced to 0, 0 and NOP.
//   - Latency: an entry pushed at edge N is visible on out_* with out_valid = 1 after edge N.
//     This is a one-cycle minimum latency. There is no same-cycle bypass from in_* to out_*.
//   - Pointer and count updates at each edge:
//       push only   -> write entry, wr_ptr+1, count+1
//       pop only    -> rd_ptr+1, count-1
//       push & pop  -> write and advance both pointers; count unchanged (legal only when 0 < count < DEPTH)
//       neither     -> hold
//   - Flush (flush = 1 at edge N):
//       wr_ptr, rd_ptr and count are all cleared to 0 at edge N.
//       Any in_* offered during cycle N is dropped (in_ready is 0 that cycle).
//       out_valid is 0 during cycle N, so decode never consumes a stale entry.
//   - Reset (rst = 1 at edge): wr_ptr = rd_ptr = 0, count = 0.
//     In the cycle after reset: out_valid = 0, in_ready = 1, out_pc = 0, out_pc_next = 0,
//     out_instruction = NOP. Storage contents are don't-care after reset.
//     rst has priority over flush and over any push/pop; reset mid-stream drops every entry.
//   - Empty: a pop is impossible (out_valid = 0); a push makes out_valid = 1 on the next cycle.
//   - Full: count == DEPTH, in_ready = 0; a pop alone frees one slot, and in_ready = 1 the next cycle.
//   - count never exceeds DEPTH and never underflows. Assertions check both; they are excluded from synthesis.
// TESTING
//   1 Reset: rst = 1 for 2 cycles, then low
//       -> out_valid = 0, in_ready = 1, count = 0, out_instruction = 32'h00000013, out_pc = 0.
//   2 Stream: push pc = 0x0, 0x4, 0x8 (instr 0x00500093, 0x00a00113, 0x002081b3) with out_ready = 1
//       -> each appears exactly one cycle after acceptance, in order; count toggles between 0 and 1.
//   3 Fill/stall: out_ready = 0, push 3 entries with DEPTH = 2
//       -> third entry sees in_ready = 0 and is held by fetch; count = 2.
//       Then out_ready = 1 for one cycle -> pc 0x0 is consumed, in_ready = 1 the next cycle.
//   4 Simultaneous: count = 1, push pc 0xC and pop pc 0x8 in the same cycle
//       -> count stays 1 and out_pc = 0xC on the next cycle.
//   5 Flush: count = 2 and in_valid = 1 with pc 0x10, flush = 1 for one cycle
//       -> in_ready = 0 and out_valid = 0 that cycle; count = 0 next cycle; pc 0x10 is never output.
//       Push pc 0x40 -> out_pc = 0x40.
//   6 Wrap: 10 push/pop pairs across pointer wrap-around -> outputs stay in order with no loss or duplicates.
//       Assert rst while count = 2 -> empty with NOP outputs the next cycle.

Source files
------------

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: decoupling FIFO between instruction fetch and decode.
// Holds {pc, pc_next, instruction} entries in a circular buffer, hands them to
// decode in order, and drops everything in one cycle on a branch redirect.
module fetch_decode_queue #(
    parameter int unsigned     DEPTH = 2,
    parameter int unsigned     XLEN  = 32,
    parameter logic [XLEN-1:0] NOP   = XLEN'(32'h00000013)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [XLEN-1:0]            in_pc_i,
    input  logic [XLEN-1:0]            in_pc_next_i,
    input  logic [XLEN-1:0]            in_instruction_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [XLEN-1:0]            out_pc_o,
    output logic [XLEN-1:0]            out_pc_next_o,
    output logic [XLEN-1:0]            out_instruction_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_next;
        logic [XLEN-1:0] instr;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty;
    logic          push;
    logic          pop;
    entry_t        head;

    // Handshake: in_ready looks only at occupancy and flush, never at out_ready,
    // so a full queue refuses a push even when decode pops in the same cycle.
    assign empty       = (count_q == '0);
    assign in_ready_o  = (count_q != FULL) & ~flush_i;
    assign out_valid_o = ~empty & ~flush_i;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign count_o     = count_q;

    // Head entry is read straight from storage; an empty queue shows a bubble.
    assign head              = mem_q[rd_ptr_q];
    assign out_pc_o          = empty ? '0  : head.pc;
    assign out_pc_next_o     = empty ? '0  : head.pc_next;
    assign out_instruction_o = empty ? NOP : head.instr;

    // Next-state pointers and occupancy; flush wipes the queue regardless of handshakes.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state: reset has priority over flush and any handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is data only and carries no reset.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            mem_q[wr_ptr_q] <= '{pc: in_pc_i, pc_next: in_pc_next_i, instr: in_instruction_i};
        end
    end

`ifndef SYNTHESIS
    // Occupancy must stay within 0..DEPTH; no push into full, no pop from empty.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (count_q <= FULL)
                else $error("fetch_decode_queue: count above DEPTH");
            assert (!(push && !pop && count_q == FULL))
                else $error("fetch_decode_queue: push into full queue");
            assert (!(pop && !push && count_q == '0))
                else $error("fetch_decode_queue: pop from empty queue");
        end
    end
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: directed and randomized checks of the fetch/decode
// queue against an ordered-list reference model.
module tb_fetch_decode_queue;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc, in_pc_next, in_instruction;
    logic [31:0] out_pc, out_pc_next, out_instruction;
    logic [1:0]  count;

    always #5 clk = ~clk;

    fetch_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NOP(NOP)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .in_pc_i          (in_pc),
        .in_pc_next_i     (in_pc_next),
        .in_instruction_i (in_instruction),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_pc_o         (out_pc),
        .out_pc_next_o    (out_pc_next),
        .out_instruction_o(out_instruction),
        .count_o          (count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t model_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   known  = 0;
    bit   acc_s;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, clock, update the model.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
        int sz;
        bit con;
        rst = r; flush = f; in_valid = iv; out_ready = ordy;
        in_pc = pc; in_pc_next = pc + 32'd4; in_instruction = ins;
        #2;
        sz = model_q.size();
        if (known && !r) begin
            chk("in_ready",    64'(in_ready),        64'((sz < DEPTH) && !f));
            chk("out_valid",   64'(out_valid),       64'((sz > 0) && !f));
            chk("count",       64'(count),           64'(sz));
            chk("out_pc",      64'(out_pc),          64'(sz > 0 ? model_q[0].pc : 32'd0));
            chk("out_pc_next", 64'(out_pc_next),     64'(sz > 0 ? model_q[0].pc + 32'd4 : 32'd0));
            chk("out_instr",   64'(out_instruction), 64'(sz > 0 ? model_q[0].instr : NOP));
        end
        acc_s = iv && (sz < DEPTH) && !f;
        con   = ordy && (sz > 0) && !f;
        @(posedge clk);
        #1;
        if (r || f) begin
            model_q.delete();
        end else begin
            if (con)   void'(model_q.pop_front());
            if (acc_s) model_q.push_back('{pc, ins});
        end
        if (r) known = 1;
    endtask

    initial begin
        logic [31:0] pend_pc, pend_ins, next_pc;
        bit          pend;
        bit          f, o;

        // Reset held for two cycles
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_count",     64'(count),     64'd0);
        chk("rst_instr",     64'(out_instruction), 64'(NOP));
        chk("rst_pc",        64'(out_pc),    64'd0);
        step(0, 0, 0, 0, 0, 1);

        // Stream with decode always ready
        step(0, 0, 1, 32'h0, 32'h00500093, 1);
        #1; chk("stream_pc0", 64'(out_pc), 64'h0); chk("stream_v0", 64'(out_valid), 64'd1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 32'h4, 32'h00a00113, 1);
        #1; chk("stream_pc4", 64'(out_pc), 64'h4);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 32'h8, 32'h002081b3, 1);
        #1; chk("stream_ins8", 64'(out_instruction), 64'h002081b3);
        step(0, 0, 0, 0, 0, 1);
        #1; chk("stream_empty", 64'(count), 64'd0);

        // Fill and stall
        step(0, 0, 1, 32'h0, 32'h00500093, 0);
        step(0, 0, 1, 32'h4, 32'h00a00113, 0);
        #1;
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_count",    64'(count),    64'd2);
        step(0, 0, 1, 32'h8, 32'h002081b3, 0);
        step(0, 0, 1, 32'h8, 32'h002081b3, 1);
        #1;
        chk("freed_in_ready", 64'(in_ready), 64'd1);
        chk("freed_pc",       64'(out_pc),   64'h4);
        step(0, 0, 1, 32'h8, 32'h002081b3, 1);

        // Simultaneous push and pop at count 1
        step(0, 0, 1, 32'hC, 32'h00000533, 1);
        #1;
        chk("simul_count", 64'(count),  64'd1);
        chk("simul_pc",    64'(out_pc), 64'hC);

        // Flush with a full queue and an offer pending
        step(0, 0, 1, 32'h20, 32'h11111111, 0);
        #1; chk("preflush_count", 64'(count), 64'd2);
        step(0, 1, 1, 32'h10, 32'h22222222, 1);
        #1; chk("flush_count", 64'(count), 64'd0);
        step(0, 0, 1, 32'h40, 32'h33333333, 0);
        #1; chk("postflush_pc", 64'(out_pc), 64'h40);
        step(0, 0, 0, 0, 0, 1);

        // Wrap: ten push/pop pairs
        step(0, 0, 1, 32'h100, $urandom, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 32'h104 + 32'(4 * i), $urandom, 1);
        step(0, 0, 0, 0, 0, 1);

        // Randomized traffic; fetch holds an offer until it is taken or flushed
        pend = 0; next_pc = 32'h1000; pend_pc = 0; pend_ins = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1; pend_pc = next_pc; pend_ins = $urandom; next_pc += 32'd4;
            end
            f = ($urandom_range(0, 15) == 0);
            o = ($urandom_range(0, 2) != 0);
            step(0, f, pend, pend_pc, pend_ins, o);
            if (acc_s || f) pend = 0;
        end

        // Reset mid-stream with a full queue
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 32'h200, 32'h44444444, 0);
        step(0, 0, 1, 32'h204, 32'h55555555, 0);
        #1; chk("prerst_count", 64'(count), 64'd2);
        step(1, 0, 0, 0, 0, 0);
        #1;
        chk("midrst_count", 64'(count),           64'd0);
        chk("midrst_valid", 64'(out_valid),       64'd0);
        chk("midrst_instr", 64'(out_instruction), 64'(NOP));
        chk("midrst_pc",    64'(out_pc_next),     64'd0);
        step(0, 0, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
